// File: rtl/reducer_pipe_7_3_if.sv
// Operand/result bundle for reducer_pipe_7_3. The master side presents operands and
// accepts results, and the slave side is the reducer itself.
interface reducer_pipe_7_3_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = WIDTH + 3
);
  logic [WIDTH-1:0] a1, a2, a3, a4, a5, a6, a7;
  logic [6:0]       op_mask;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_tag;
  logic [OUT_W-1:0] sum;
  logic [3:0]       out_tag;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output a1, a2, a3, a4, a5, a6, a7, op_mask, in_valid, in_tag, out_ready,
    input  in_ready, sum, out_tag, out_valid, busy
  );

  modport slave (
    input  a1, a2, a3, a4, a5, a6, a7, op_mask, in_valid, in_tag, out_ready,
    output in_ready, sum, out_tag, out_valid, busy
  );
endinterface

// File: rtl/reducer_pipe_7_3.sv
// Three-stage 7-operand adder: 7:3 column counters, a 3:2 compressor, then a CPA.
// Define REDUCER_SIGNED_EN for two's-complement operands. The default build is unsigned.
module reducer_pipe_7_3 #(
  parameter int WIDTH = 32,
  parameter int OUT_W = WIDTH + 3
) (
  input  logic              clock,
  input  logic              clear,
  reducer_pipe_7_3_if.slave bus
);
  localparam int EXT = OUT_W - WIDTH;

  logic [WIDTH-1:0] op  [7];
  logic [OUT_W-1:0] ext [7];
  logic [OUT_W-1:0] col_b0, col_b1, col_b2;
  logic [2:0]       col_cnt;
  logic [OUT_W-1:0] s_n, c1_n, c2_n, x_n, y_n;

  logic             v1, v2;
  logic [3:0]       t1, t2;
  logic [OUT_W-1:0] s_r, c1_r, c2_r, x_r, y_r;
  logic             adv;

  assign op[0] = bus.a1;
  assign op[1] = bus.a2;
  assign op[2] = bus.a3;
  assign op[3] = bus.a4;
  assign op[4] = bus.a5;
  assign op[5] = bus.a6;
  assign op[6] = bus.a7;

  // Operands are widened to the full result width first, so a signed sum wraps correctly mod 2^OUT_W.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      ext[k] = '0;
      if (bus.op_mask[k]) begin
`ifdef REDUCER_SIGNED_EN
        ext[k] = {{EXT{op[k][WIDTH-1]}}, op[k]};
`else
        ext[k] = {{EXT{1'b0}}, op[k]};
`endif
      end
    end
  end

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    col_b0  = '0;
    col_b1  = '0;
    col_b2  = '0;
    col_cnt = '0;
    for (int i = 0; i < OUT_W; i++) begin
      col_cnt = '0;
      for (int k = 0; k < 7; k++) col_cnt = col_cnt + 3'(ext[k][i]);
      col_b0[i] = col_cnt[0];
      col_b1[i] = col_cnt[1];
      col_b2[i] = col_cnt[2];
    end
  end

  assign s_n  = col_b0;
  assign c1_n = col_b1 << 1;
  assign c2_n = col_b2 << 2;

  assign x_n = s_r ^ c1_r ^ c2_r;
  assign y_n = ((s_r & c1_r) | (s_r & c2_r) | (c1_r & c2_r)) << 1;

  // NOTE: a single enable moves every stage together. A stall therefore freezes bubbles in place and never collapses them.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.busy     = v1 || v2 || bus.out_valid;

  // NOTE: non-blocking assignments, so each stage reads its predecessor's pre-edge value.
  always_ff @(posedge clock) begin
    if (clear) begin
      v1            <= 1'b0;
      t1            <= '0;
      s_r           <= '0;
      c1_r          <= '0;
      c2_r          <= '0;
      v2            <= 1'b0;
      t2            <= '0;
      x_r           <= '0;
      y_r           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_tag   <= '0;
      bus.sum       <= '0;
    end else if (adv) begin
      v1            <= bus.in_valid;
      t1            <= bus.in_tag;
      s_r           <= s_n;
      c1_r          <= c1_n;
      c2_r          <= c2_n;
      v2            <= v1;
      t2            <= t1;
      x_r           <= x_n;
      y_r           <= y_n;
      bus.out_valid <= v2;
      bus.out_tag   <= t2;
      bus.sum       <= x_r + y_r;
    end
  end
endmodule

// File: tb/tb_reducer_pipe_7_3.sv
// Self-checking bench for reducer_pipe_7_3: a queue-based model of the masked sum, checked every cycle,
// with hand-computed literal results for the fixed cases.
module tb_reducer_pipe_7_3;
  localparam int WIDTH = 32;
  localparam int OUT_W = WIDTH + 3;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  reducer_pipe_7_3_if #(.WIDTH(WIDTH), .OUT_W(OUT_W)) bus ();
  reducer_pipe_7_3 #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  logic [WIDTH-1:0] a [7];
  assign bus.a1 = a[0];
  assign bus.a2 = a[1];
  assign bus.a3 = a[2];
  assign bus.a4 = a[3];
  assign bus.a5 = a[4];
  assign bus.a6 = a[5];
  assign bus.a7 = a[6];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the plain arithmetic sum of the enabled operands, taken mod 2^OUT_W.
  function automatic logic [OUT_W-1:0] model_sum(input logic [6:0] m);
    logic [OUT_W-1:0]        acc;
    logic signed [OUT_W-1:0] sx;
    acc = '0;
    for (int k = 0; k < 7; k++) begin
      if (m[k]) begin
`ifdef REDUCER_SIGNED_EN
        sx  = $signed(a[k]);
        acc = acc + sx;
`else
        acc = acc + OUT_W'(a[k]);
`endif
      end
    end
    return acc;
  endfunction

  typedef struct {
    logic [OUT_W-1:0] sum;
    logic [3:0]       tag;
    int               adv_at;
  } beat_t;

  beat_t            q[$];
  int               adv_count = 0;
  int               n_acc     = 0;
  int               n_xfer    = 0;
  bit               head_seen = 1'b0;
  bit               prev_hold = 1'b0;
  logic [OUT_W-1:0] prev_sum;
  logic [3:0]       prev_tag;

  // Compare process. It runs on every falling edge, when inputs and outputs are stable.
  always @(negedge clock) begin
    if (clear) begin
      q.delete();
      head_seen = 1'b0;
      prev_hold = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, 64'(!bus.out_valid || bus.out_ready));
      check("busy", bus.busy, 64'(q.size() != 0));
      if (prev_hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_sum", bus.sum, prev_sum);
        check("hold_tag", bus.out_tag, prev_tag);
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: out_valid=1 tag=%0d expected no beat in flight at %0t",
                   bus.out_tag, $time);
        end else begin
          if (!head_seen) begin
            check("latency", 64'(adv_count - q[0].adv_at), 3);
            head_seen = 1'b1;
          end
          if (bus.out_ready) begin
            check("sum", bus.sum, q[0].sum);
            check("tag", bus.out_tag, q[0].tag);
            void'(q.pop_front());
            head_seen = 1'b0;
            n_xfer++;
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_sum  = bus.sum;
      prev_tag  = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{model_sum(bus.op_mask), bus.in_tag, adv_count});
        n_acc++;
      end
      if (bus.in_ready) adv_count++;
    end
  end

  // Presents one beat to an idle pipeline and expects its result exactly 3 cycles later.
  task automatic send_one(input logic [6:0] m, input logic [3:0] t,
                          input logic [OUT_W-1:0] exp, input string name);
    int lat;
    bus.op_mask   = m;
    bus.in_tag    = t;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      lat++;
      if (bus.out_valid) break;
    end
    check({name, "_lat"}, 64'(lat), 3);
    check({name, "_sum"}, bus.sum, exp);
    check({name, "_tag"}, bus.out_tag, t);
    @(posedge clock); #1;
  endtask

  initial begin
    int n0;
    int guard;
    clear         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 4'hA;
    bus.op_mask   = 7'h7F;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) a[k] = WIDTH'(k + 1);

    // A beat presented during clear must not be accepted.
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_sum", bus.sum, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clock); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clock); #1;

    for (int k = 0; k < 7; k++) a[k] = '1;
`ifdef REDUCER_SIGNED_EN
    send_one(7'h7F, 4'd5, 35'h7FFFFFFF9, "all_ones");
`else
    send_one(7'h7F, 4'd5, 35'h6FFFFFFF9, "all_ones");
`endif
    for (int k = 0; k < 7; k++) a[k] = 32'h8000_0000;
`ifdef REDUCER_SIGNED_EN
    send_one(7'h7F, 4'd2, 35'h480000000, "msb_only");
`else
    send_one(7'h7F, 4'd2, 35'h380000000, "msb_only");
`endif
    for (int k = 0; k < 7; k++) a[k] = WIDTH'(k + 1);
    send_one(7'h55, 4'd3, 35'd16, "odd_mask");
    send_one(7'h00, 4'd4, 35'd0, "zero_mask");

    // Four back-to-back beats, with the consumer stalling in cycles 4 to 6.
    n0 = n_xfer;
    for (int c = 0; c < 14; c++) begin
      bus.in_valid  = (c < 4);
      bus.in_tag    = c[3:0];
      bus.op_mask   = 7'(1 << c);
      bus.out_ready = !(c >= 4 && c <= 6);
      @(negedge clock);
      if (c == 5) begin
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_out_tag", bus.out_tag, 1);
        check("stall_sum", bus.sum, 2);
      end
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    check("b2b_count", 64'(n_xfer - n0), 4);

    // Two beats in flight, then a one-cycle clear. Neither beat may produce a result.
    bus.op_mask = 7'h7F;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (c < 3);
      bus.in_tag   = 4'(6 + c);
      clear        = (c == 2);
      @(negedge clock);
      if (c == 3) begin
        check("flush_busy", bus.busy, 0);
        check("flush_out_valid", bus.out_valid, 0);
      end
      @(posedge clock); #1;
    end
    clear = 1'b0;
    send_one(7'h7F, 4'd11, 35'd28, "after_clear");

    // Random traffic with random valid/ready, plus an occasional clear.
    n0    = n_acc;
    guard = 0;
    while ((n_acc - n0) < 10000 && guard < 60000) begin
      for (int k = 0; k < 7; k++) begin
        case ($urandom % 4)
          0:       a[k] = '1;
          1:       a[k] = '0;
          default: a[k] = WIDTH'($urandom);
        endcase
      end
      bus.op_mask   = 7'($urandom);
      bus.in_tag    = 4'($urandom);
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 4) != 0;
      clear         = ($urandom % 800) == 0;
      @(posedge clock); #1;
      guard++;
    end
    clear = 1'b0;
    check("random_budget", 64'(guard < 60000), 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("drain", 64'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reducer_pipe_7_3.md
REDUCER_PIPE_7_3 -- requirements
Module: reducer_pipe_7_3

Interface
- REQ-001: Parameter WIDTH, default 32, operand width in bits (legal range 4..64).
- REQ-002: Parameter OUT_W, default WIDTH+3, result width; fixed at WIDTH+3.
- REQ-003: Port clock, input, 1, sole clock; all state updates on the rising edge.
- REQ-004: Port clear, input, 1, reset; synchronous, active-high.
- REQ-005: Ports a1..a7, input, WIDTH each, the seven addend operands.
- REQ-006: Port op_mask, input, 7, per-operand enable; bit k-1 low forces operand ak to zero.
- REQ-007: Port in_valid, input, 1, operands, op_mask and in_tag are presented.
- REQ-008: Port in_ready, output, 1, block accepts a beat this cycle.
- REQ-009: Port in_tag, input, 4, caller tag carried alongside the operands.
- REQ-010: Port sum, output, OUT_W, final reduced sum.
- REQ-011: Port out_tag, output, 4, tag of the beat on sum.
- REQ-012: Port out_valid, output, 1, sum and out_tag are valid.
- REQ-013: Port out_ready, input, 1, consumer accepts the result.
- REQ-014: Port busy, output, 1, any pipeline stage holds a valid beat.

Function
- REQ-015: Beat accepted when in_valid and in_ready are both high; result transferred when out_valid and out_ready are both high.
- REQ-016: Stage 1 (registered) compresses masked operands per bit column via 7:3 counters into s (WIDTH), c1 (WIDTH+1, shifted left 1) and c2 (WIDTH+2, shifted left 2).
- REQ-017: Stage 2 (registered) compresses s, c1, c2 via 3:2 full adders into two OUT_W vectors.
- REQ-018: Stage 3 (registered) adds the two vectors with a carry-propagate adder into sum.
- REQ-019: Latency SHALL be exactly 3 cycles from acceptance to out_valid when out_ready stays high; throughput one beat per cycle.
- REQ-020: Each stage carries a valid bit and the tag; tags SHALL emerge in acceptance order.
- REQ-021: Global stall: in_ready = !out_valid || out_ready; when in_ready is low no stage register changes.
- REQ-022: While stalled, sum, out_tag and out_valid SHALL hold stable.
- REQ-023: Bubbles (in_valid low while in_ready high) propagate as invalid stages; stalls SHALL NOT collapse bubbles.
- REQ-024: busy = OR of all three stage valid bits.
- REQ-025: Result SHALL equal the exact arithmetic sum of masked operands; OUT_W bits SHALL never overflow (7*(2^WIDTH-1) < 2^(WIDTH+3)).
- REQ-026: op_mask = 0 with in_valid yields sum = 0 after 3 cycles.

Reset
- REQ-027: clear high at a rising edge zeroes all stage valid bits, tags and data registers; sum=0, out_tag=0, out_valid=0, busy=0.
- REQ-028: clear mid-operation discards all in-flight beats; no result for them SHALL appear.
- REQ-029: in_ready SHALL be high in the cycle after clear deasserts; a beat presented during clear is not accepted.

Configuration
- REQ-030: Macro REDUCER_SIGNED_EN defined: operands are two's complement, sign-extended to OUT_W before compression; sum is signed OUT_W.
- REQ-031: Macro REDUCER_SIGNED_EN undefined: operands are unsigned, zero-extended; sum is unsigned OUT_W.

Verification
- REQ-032: Unsigned, WIDTH=32, all a=0xFFFFFFFF, op_mask=0x7F, tag=5 -> cycle 3: sum=0x6FFFFFFF9, out_tag=5.
- REQ-033: a1..a7=1..7, op_mask=0x55 (a1,a3,a5,a7) -> sum=16; op_mask=0x00 -> sum=0.
- REQ-034: Back-to-back 4 beats tags 0..3, out_ready low cycles 4-6 -> sum/out_tag held, in_ready low, then results in order 0,1,2,3, none lost or duplicated.
- REQ-035: Two beats in flight, clear pulsed one cycle -> out_valid never asserts for them; busy=0 next cycle; new beat 3 cycles later correct.
- REQ-036: REDUCER_SIGNED_EN, all a=0xFFFFFFFF, mask 0x7F -> sum = -7 (0x7FFFFFFF9 in 35 bits).
- REQ-037: Random 10k beats with random valid/ready toggling -> every sum matches reference model, tags in order.
